// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit_pkg
//  Purpose  : Shared ISA constants and fetch-stage types for the front end.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pc_unit_pkg;

    localparam int c_PC_W = 12;

    // Instruction field positions
    localparam int c_OPCODE_MSB = 31;
    localparam int c_OPCODE_LSB = 27;
    localparam int c_TARGET_MSB = 26;
    localparam int c_IMM_MSB    = 16;

    localparam logic [4:0] c_OP_ADD  = 5'b00000;
    localparam logic [4:0] c_OP_J    = 5'b00001;
    localparam logic [4:0] c_OP_BNE  = 5'b00010;
    localparam logic [4:0] c_OP_JAL  = 5'b00011;
    localparam logic [4:0] c_OP_JR   = 5'b00100;
    localparam logic [4:0] c_OP_ADDI = 5'b00101;
    localparam logic [4:0] c_OP_BLT  = 5'b00110;
    localparam logic [4:0] c_OP_SW   = 5'b00111;
    localparam logic [4:0] c_OP_LW   = 5'b01000;
    localparam logic [4:0] c_OP_SETX = 5'b10101;
    localparam logic [4:0] c_OP_BEX  = 5'b10110;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_TARGET = 2'd1,
        SEL_REG    = 2'd2,
        SEL_BRANCH = 2'd3
    } npc_sel_e;

    function automatic logic [31:0] sext_imm(input logic [c_IMM_MSB:0] imm);
        return {{(31 - c_IMM_MSB){imm[c_IMM_MSB]}}, imm};
    endfunction

    function automatic logic [4:0] get_opcode(input logic [31:0] instr);
        return instr[c_OPCODE_MSB:c_OPCODE_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_unit_next_pc_sel.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit_next_pc_sel
//  Purpose  : Taken detection, redirect target priority mux and branch adder.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_pc_unit_next_pc_sel
    import fetch_pc_unit_pkg::*;
#(
    parameter int PC_W = c_PC_W
) (
    input  logic [PC_W-1:0] i_ex_pc,
    input  logic            i_ex_is_j,
    input  logic            i_ex_is_jal,
    input  logic            i_ex_is_jr,
    input  logic            i_ex_is_bne,
    input  logic            i_ex_is_blt,
    input  logic            i_ex_is_bex,
    input  logic [16:0]     i_ex_imm,
    input  logic [26:0]     i_ex_target,
    input  logic [31:0]     i_ex_rd_val,
    input  logic            i_cmp_ne,
    input  logic            i_cmp_lt,
    input  logic            i_rstatus_nz,
    output logic            o_taken,
    output logic [PC_W-1:0] o_target,
    output logic [PC_W-1:0] o_pc_plus1
);

    logic [31:0]     w_imm_ext;
    logic [PC_W-1:0] w_pc_plus1;
    logic [PC_W-1:0] w_branch_target;
    logic            w_bex_tk;
    logic            w_blt_tk;
    logic            w_bne_tk;
    npc_sel_e        w_sel;
    logic            w_unused;

    assign w_imm_ext       = sext_imm(i_ex_imm);
    assign w_pc_plus1      = i_ex_pc + PC_W'(1);
    assign w_branch_target = w_pc_plus1 + w_imm_ext[PC_W-1:0];

    assign w_bex_tk = i_ex_is_bex & i_rstatus_nz;
    assign w_blt_tk = i_ex_is_blt & i_cmp_lt;
    assign w_bne_tk = i_ex_is_bne & i_cmp_ne;

    // Illegal multi-type combinations still resolve deterministically
    always_comb begin
        w_sel = SEL_SEQ;
        if (w_bex_tk)
            w_sel = SEL_TARGET;
        else if (i_ex_is_jr)
            w_sel = SEL_REG;
        else if (i_ex_is_jal | i_ex_is_j)
            w_sel = SEL_TARGET;
        else if (w_blt_tk | w_bne_tk)
            w_sel = SEL_BRANCH;
    end

    always_comb begin
        o_target = '0;
        case (w_sel)
            SEL_TARGET: o_target = i_ex_target[PC_W-1:0];
            SEL_REG:    o_target = i_ex_rd_val[PC_W-1:0];
            SEL_BRANCH: o_target = w_branch_target;
            default:    o_target = '0;
        endcase
    end

    assign o_taken    = (w_sel != SEL_SEQ);
    assign o_pc_plus1 = w_pc_plus1;

    // Upper target/register/immediate bits beyond the PC width are ignored
    assign w_unused = ^{i_ex_target, i_ex_rd_val, w_imm_ext};

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit
//  Purpose  : Fetch stage: owns the PC, drives imem, redirects on taken CTI.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              PC_W     = c_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_q,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic            if_valid,
    output logic            flush,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_is_j,
    input  logic            ex_is_jal,
    input  logic            ex_is_jr,
    input  logic            ex_is_bne,
    input  logic            ex_is_blt,
    input  logic            ex_is_bex,
    input  logic [16:0]     ex_imm,
    input  logic [26:0]     ex_target,
    input  logic [31:0]     ex_rd_val,
    input  logic            cmp_ne,
    input  logic            cmp_lt,
    input  logic            rstatus_nz,
    output logic [31:0]     link_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_fpc;
    logic            r_fvalid;
    logic            r_hold;
    logic [31:0]     r_hold_instr;

    logic            w_taken;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_plus1;

    fetch_pc_unit_next_pc_sel #(
        .PC_W (PC_W)
    ) u_next_pc_sel (
        .i_ex_pc      (ex_pc),
        .i_ex_is_j    (ex_is_j),
        .i_ex_is_jal  (ex_is_jal),
        .i_ex_is_jr   (ex_is_jr),
        .i_ex_is_bne  (ex_is_bne),
        .i_ex_is_blt  (ex_is_blt),
        .i_ex_is_bex  (ex_is_bex),
        .i_ex_imm     (ex_imm),
        .i_ex_target  (ex_target),
        .i_ex_rd_val  (ex_rd_val),
        .i_cmp_ne     (cmp_ne),
        .i_cmp_lt     (cmp_lt),
        .i_rstatus_nz (rstatus_nz),
        .o_taken      (w_taken),
        .o_target     (w_target),
        .o_pc_plus1   (w_pc_plus1)
    );

    // Redirect beats stall; the word fetched from the old path is marked invalid
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_fpc        <= '0;
            r_fvalid     <= 1'b0;
            r_hold       <= 1'b0;
            r_hold_instr <= '0;
        end else if (w_taken) begin
            r_pc     <= w_target;
            r_fpc    <= r_pc;
            r_fvalid <= 1'b0;
            r_hold   <= 1'b0;
        end else if (stall) begin
            if (!r_hold) begin
                r_hold_instr <= imem_q;
                r_hold       <= 1'b1;
            end
        end else begin
            r_pc     <= r_pc + PC_W'(1);
            r_fpc    <= r_pc;
            r_fvalid <= 1'b1;
            r_hold   <= 1'b0;
        end
    end

    assign imem_addr = reset ? RESET_PC : r_pc;
    assign if_instr  = r_hold ? r_hold_instr : imem_q;
    assign if_pc     = r_fpc;
    assign if_valid  = r_fvalid & ~reset;
    assign flush     = w_taken & ~reset;
    assign link_pc   = {{(32 - PC_W){1'b0}}, w_pc_plus1};

endmodule
`default_nettype wire
